// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned NDIG  = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned DIG_W = 7;
  localparam int unsigned ACC_W = NDIG * NIB_W;

  typedef logic [DIG_W-1:0] dig_t;

  localparam dig_t        DIG_BLANK = 7'h10;
  localparam logic [26:0] BCD_MAX   = 27'd99_999_999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus the eight digit codes feeding the display controller.
interface bin2bcd_seq_if #(
  parameter int unsigned W = 27
);
  import bin2bcd_pkg::*;

  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         ovf;
  dig_t         d7, d6, d5, d4, d3, d2, d1, d0;

  modport master (
    output start, bin,
    input  busy, done, ovf, d7, d6, d5, d4, d3, d2, d1, d0
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, d7, d6, d5, d4, d3, d2, d1, d0
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock, registered digit outputs.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W   = 27,
  parameter bit          LZB = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(W);
  localparam dig_t        RST_HI = LZB ? DIG_BLANK : '0;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       sr;
  logic [ACC_W-1:0]   acc, acc_adj;
  logic               ovf_pend;
  logic               accept_c, load_c;
  logic               lead_c;
  dig_t               dig_c [NDIG];
  dig_t               dig_q [NDIG];
  logic               busy_q, done_q, ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    load_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: if (cnt == '0) state_nx = LOAD;
      LOAD: begin
        load_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[i*NIB_W +: NIB_W]),
      .dout (acc_adj[i*NIB_W +: NIB_W])
    );
  end

  // Overflow is decided at capture time since sr is consumed by the shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      sr       <= '0;
      acc      <= '0;
      ovf_pend <= 1'b0;
    end else if (accept_c) begin
      sr       <= bus.bin;
      acc      <= '0;
      cnt      <= CNT_W'(W - 1);
      ovf_pend <= (32'(bus.bin) > 32'(BCD_MAX));
    end else if (state == SHIFT) begin
      acc <= ACC_W'({acc_adj, sr[W-1]});
      sr  <= sr << 1;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  // Leading-zero blanking walks down from d7 until the first non-zero digit.
  always_comb begin
    lead_c   = LZB;
    dig_c[0] = dig_t'(acc[NIB_W-1:0]);
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (lead_c && acc[k*NIB_W +: NIB_W] == '0) begin
        dig_c[k] = DIG_BLANK;
      end else begin
        lead_c   = 1'b0;
        dig_c[k] = dig_t'(acc[k*NIB_W +: NIB_W]);
      end
    end
    if (ovf_pend) begin
      for (int k = 0; k < NDIG; k++) dig_c[k] = DIG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      dig_q[0] <= '0;
      for (int k = 1; k < NDIG; k++) dig_q[k] <= RST_HI;
    end else begin
      busy_q <= (state_nx != IDLE);
      done_q <= load_c;
      if (load_c) begin
        ovf_q <= ovf_pend;
        dig_q <= dig_c;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.d0   = dig_q[0];
  assign bus.d1   = dig_q[1];
  assign bus.d2   = dig_q[2];
  assign bus.d3   = dig_q[3];
  assign bus.d4   = dig_q[4];
  assign bus.d5   = dig_q[5];
  assign bus.d6   = dig_q[6];
  assign bus.d7   = dig_q[7];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: one instance with blanking, one without, driven in lockstep.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  int          checks = 0;
  int          errors = 0;

  bin2bcd_seq_if #(.W(27)) b1 ();
  bin2bcd_seq_if #(.W(27)) b0 ();

  assign b1.start = start;
  assign b1.bin   = bin;
  assign b0.start = start;
  assign b0.bin   = bin;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(27), .LZB(1'b1)) u_dut_lzb (.clk(clk), .rst(rst), .bus(b1));
  bin2bcd_seq #(.W(27), .LZB(1'b0)) u_dut_nolzb (.clk(clk), .rst(rst), .bus(b0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected digits written one byte per digit (d7 first), packed to 7-bit codes.
  function automatic logic [55:0] exp8(input logic [63:0] b);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = b[i*8 +: 7];
    return r;
  endfunction

  task automatic check_digs(input string tag, input logic [63:0] e1, input logic [63:0] e0);
    check({tag, "_lzb1"}, 64'({b1.d7, b1.d6, b1.d5, b1.d4, b1.d3, b1.d2, b1.d1, b1.d0}), 64'(exp8(e1)));
    check({tag, "_lzb0"}, 64'({b0.d7, b0.d6, b0.d5, b0.d4, b0.d3, b0.d2, b0.d1, b0.d0}), 64'(exp8(e0)));
  endtask

  // One conversion; optionally pokes start with a different bin mid-conversion.
  task automatic run(input string tag, input logic [26:0] v, input bit pulses);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (pulses && (n == 5 || n == 10)) begin
        start = 1'b1;
        bin   = 27'd7777;
      end else begin
        start = 1'b0;
      end
      if (b1.done) begin
        lat = n;
        break;
      end
      if (!b1.busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd28);
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(b1.busy), 64'd0);
    check({tag, "_done_nolzb"}, 64'(b0.done), 64'd1);
    @(posedge clk);
    #1 check({tag, "_done_width"}, 64'(b1.done), 64'd0);
  endtask

  initial begin
    int  gap;
    bit  saw_done;
    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(b1.busy), 64'd0);
    check("rst_done", 64'(b1.done), 64'd0);
    check("rst_ovf", 64'(b1.ovf), 64'd0);
    check_digs("rst_digs", 64'h10101010_10101000, 64'h0);
    @(negedge clk) rst = 1'b1;

    run("zero", 27'd0, 1'b0);
    check_digs("zero_digs", 64'h10101010_10101000, 64'h0);

    run("v12345678", 27'd12_345_678, 1'b0);
    check_digs("v12345678_digs", 64'h01020304_05060708, 64'h01020304_05060708);
    check("v12345678_ovf", 64'(b1.ovf), 64'd0);

    run("vmax", 27'd99_999_999, 1'b0);
    check_digs("vmax_digs", 64'h09090909_09090909, 64'h09090909_09090909);
    check("vmax_ovf", 64'(b1.ovf), 64'd0);

    run("vovf", 27'd100_000_000, 1'b0);
    check_digs("vovf_digs", 64'h10101010_10101010, 64'h10101010_10101010);
    check("vovf_ovf", 64'(b1.ovf), 64'd1);
    check("vovf_ovf_nolzb", 64'(b0.ovf), 64'd1);

    run("v405", 27'd405, 1'b0);
    check_digs("v405_digs", 64'h10101010_10040005, 64'h00000000_00040005);
    check("v405_ovf", 64'(b1.ovf), 64'd0);

    run("ignore", 27'd1234, 1'b1);
    check_digs("ignore_digs", 64'h10101010_01020304, 64'h00000000_01020304);

    // start held high: next conversion accepted in the IDLE cycle after done
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd5;
    saw_done = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (b1.done) begin
        saw_done = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 64'(saw_done), 64'd1);
    gap = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (b1.done) begin
        gap = n;
        break;
      end
    end
    start = 1'b0;
    check("b2b_gap", 64'(gap), 64'd29);
    check_digs("b2b_digs", 64'h10101010_10101005, 64'h00000000_00000005);

    // reset ten cycles into a conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd87_654_321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", 64'(b1.busy), 64'd0);
    check("midrst_done", 64'(b1.done), 64'd0);
    check_digs("midrst_digs", 64'h10101010_10101000, 64'h0);
    @(negedge clk) rst = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk);
      #1;
      if (b1.done || b0.done) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    check_digs("midrst_hold", 64'h10101010_10101000, 64'h0);

    run("v42", 27'd42, 1'b0);
    check_digs("v42_digs", 64'h10101010_10100402, 64'h00000000_00000402);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the eight-digit seven-segment display controller. It accepts an unsigned binary value on a start/busy/done handshake, converts it by shift-and-add-3 (double dabble) one bit per clock, and presents the result as eight registered 7-bit digit codes `d7..d0`. The controller's `d7..d0` inputs connect directly to these outputs. The digit outputs hold the last completed conversion until the next one finishes.

## Interface
- `W`, 27, width of the binary input. The 8-digit maximum 99_999_999 fits in 27 bits.
- `LZB`, 1, leading-zero blanking enable. When 1, leading zero digits above `d0` show as blank.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `bin` input W: value to convert. Captured on the edge that accepts `start`.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse when new digits are valid.
- `ovf` output 1: high if the last captured `bin` exceeded 99_999_999. Held until the next completion.
- `d7..d0` output 7 each: digit codes, with `d7` the most significant.
  - Code format: bits [3:0] = BCD value, bit 4 = blank, bits [6:5] = 0.

## Operation
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - If `start`=1, capture `bin` into shift register `sr`, clear the 32-bit BCD accumulator `acc`, load `cnt` = W-1, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - For each nibble of `acc` that is >= 5, add 3 to it.
  - Then shift `{acc, sr}` left by 1.
  - If `cnt`==0, go to LOAD; otherwise decrement `cnt`.
- LOAD:
  - Write the digit outputs from `acc`.
  - Set `ovf` = (captured value > 99_999_999).
  - Pulse `done`, then go to IDLE.
- Blanking (LZB=1): digit k (k = 7..1) is blank while it and all digits above it are zero. `d0` is never blank.
  - A blank digit outputs 7'h10.
  - LZB=0 disables blanking: all digits are shown, so zero digits output 7'h00.
- Overflow: when `ovf`=1, all eight digits output 7'h10 (display blank) and `acc` is discarded.
- `start` while `busy`=1 is ignored. There is no queueing, and the captured `bin` is unaffected.
- `start` held high continuously gives back-to-back conversions: a new one is accepted in the IDLE cycle after each `done`.
- `bin` is sampled once, so changes to it during a conversion have no effect.

## Timing
- Reset values, applied asynchronously on `rst`=0:
  - State IDLE, `busy`=0, `done`=0, `ovf`=0.
  - `d0` = 7'h00.
  - `d7..d1` = 7'h10 when LZB=1, 7'h00 when LZB=0.
- Reset mid-conversion aborts the conversion: the digit outputs return to their reset values and no `done` is issued.
- Latency:
  - `start` accepted at edge 0.
  - SHIFT occupies edges 1..W.
  - LOAD is the state after edge W; `done`=1 and the new digits and `ovf` appear after edge W+1.
  - For W=27, `done` is high for exactly one cycle, 28 cycles after the accepting edge.
- `busy` rises after edge 0 and falls after edge W+1. It is low in the cycle where `done` is high.
- The digit outputs change only on the LOAD edge or on reset, so the downstream scan never sees a partial result.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `bin2bcd_pkg` holds:
  - State enum `state_t` (IDLE, SHIFT, LOAD).
  - `DIG_BLANK` = 7'h10.
  - `BCD_MAX` = 27'd99_999_999.
  - `NDIG` = 8.
- Sub-module `bcd_add3`: combinational, 4-bit in / 4-bit out, adds 3 when the input is >= 5. Instantiated 8 times in a generate loop.
- The top module contains the FSM, `cnt` (width $clog2(W)), `sr`, `acc`, the blanking logic and the output registers.

## Test plan
- Reset check: assert `rst`=0 mid-sim → `busy`=0, `done`=0, `d0`=7'h00, `d7..d1`=7'h10. Release, then `bin`=0 with `start` → `done` 28 cycles later, same digit values.
- `bin`=12_345_678 → `d7..d0` = 7'h01,02,03,04,05,06,07,08; `ovf`=0; `done` exactly one cycle wide.
- `bin`=99_999_999 → all digits 7'h09. Then `bin`=100_000_000 → `ovf`=1 and all digits 7'h10.
- `bin`=405 with LZB=1 → `d2..d0` = 04,00,05 and `d7..d3` = 7'h10. Same value with LZB=0 → `d7..d3` = 7'h00.
- `start` pulses at cycles 5 and 10 after the accepting edge, with `bin` changed in between → ignored; result matches the first value; `busy` stays high throughout.
- `rst` asserted 10 cycles into a conversion of 87_654_321 → no `done`, outputs at reset values. A following conversion of 42 → `d1`=04, `d0`=02.
